// File: rtl/clk_rst_seq_if.sv
// -----------------------------------------------------------------------------
// clk_rst_seq_if
//   Bundles the board-side clocking signals of the reset sequencer.
//   The sequencer uses the master modport and the board/MMCM side uses the slave modport.
//
//   locked     MMCM/DCM lock. Asynchronous to the sequencer clock.
//   mmcm_rst   reset pulse to the MMCM/DCM.
//   rst_out    per-channel active-high resets. Bit 0 is released first.
//   ready      all channels released and lock held.
//   state      sequencer state code: 0 RST_MMCM, 1 WAIT_LOCK, 2 STABLE, 3 RELEASE, 4 RUN.
//   retries    lock-timeout retry count. Saturates at 255.
//   loss_cnt   lock-loss event count. Saturates at 255.
//   lock_loss  one-cycle pulse for each lock-loss event.
// -----------------------------------------------------------------------------
interface clk_rst_seq_if #(
  parameter int NCH = 4
);
  logic           locked;
  logic           mmcm_rst;
  logic [NCH-1:0] rst_out;
  logic           ready;
  logic [2:0]     state;
  logic [7:0]     retries;
  logic [7:0]     loss_cnt;
  logic           lock_loss;

  modport master (
    input  locked,
    output mmcm_rst, rst_out, ready, state, retries, loss_cnt, lock_loss
  );

  modport slave (
    output locked,
    input  mmcm_rst, rst_out, ready, state, retries, loss_cnt, lock_loss
  );
endinterface

// File: rtl/clk_rst_seq.sv
// -----------------------------------------------------------------------------
// clk_rst_seq
//   Clock bring-up and reset sequencer. It runs on the free-running reference
//   clock and performs these steps:
//     1. Pulses the MMCM reset.
//     2. Waits for lock, and retries after a timeout.
//     3. Qualifies the lock for a fixed number of cycles.
//     4. Releases NCH downstream resets in a staggered order, starting with bit 0.
//   If the lock drops during release or run, all resets are forced back on and
//   the whole sequence starts again.
//
//   i_clk    free-running reference clock
//   i_rst    synchronous, active-high reset
//   io_seq   clk_rst_seq_if.master (locked in; all other signals out, all registered)
// -----------------------------------------------------------------------------
module clk_rst_seq #(
  parameter int NCH          = 4,
  parameter int RST_CYCLES   = 256,
  parameter int LOCK_TIMEOUT = 65536,
  parameter int LOCK_STABLE  = 1024,
  parameter int STAGGER      = 16
) (
  input  logic                i_clk,
  input  logic                i_rst,
  clk_rst_seq_if.master       io_seq
);

  localparam int MAX_AB  = (RST_CYCLES  > LOCK_TIMEOUT) ? RST_CYCLES  : LOCK_TIMEOUT;
  localparam int MAX_CD  = (LOCK_STABLE > STAGGER)      ? LOCK_STABLE : STAGGER;
  localparam int MAX_CYC = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int CW      = $clog2(MAX_CYC) + 1;
  localparam int IW      = (NCH > 1) ? $clog2(NCH) : 1;

  localparam logic [CW-1:0] C_RST_LAST  = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] C_TO_LAST   = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] C_STB_LAST  = CW'(LOCK_STABLE - 1);
  localparam logic [CW-1:0] C_STG_LAST  = CW'(STAGGER - 1);
  localparam logic [IW-1:0] C_IDX_LAST  = IW'(NCH - 1);

  typedef enum logic [2:0] {
    ST_RST_MMCM  = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RELEASE   = 3'd3,
    ST_RUN       = 3'd4
  } state_t;

  state_t          r_state,     w_state_nxt;
  logic [CW-1:0]   r_cnt,       w_cnt_nxt;
  logic [IW-1:0]   r_idx,       w_idx_nxt;
  logic [NCH-1:0]  r_rst_out,   w_rst_out_nxt;
  logic            r_ready,     w_ready_nxt;
  logic [7:0]      r_retries,   w_retries_nxt;
  logic [7:0]      r_loss_cnt,  w_loss_cnt_nxt;
  logic            r_lock_loss, w_lock_loss_nxt;
  logic            r_mmcm_rst;
  logic            r_lk_meta, r_lk_s;

  // Next-state and next-output logic.
  always_comb begin
    // NOTE: every variable gets a default first. Otherwise a branch that does not
    // assign a variable would infer a latch.
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_idx_nxt       = r_idx;
    w_rst_out_nxt   = r_rst_out;
    w_ready_nxt     = r_ready;
    w_retries_nxt   = r_retries;
    w_loss_cnt_nxt  = r_loss_cnt;
    w_lock_loss_nxt = 1'b0;

    case (r_state)
      ST_RST_MMCM: begin
        if (r_cnt == C_RST_LAST) begin
          w_state_nxt = ST_WAIT_LOCK;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end

      ST_WAIT_LOCK: begin
        if (r_lk_s) begin
          w_state_nxt = ST_STABLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt == C_TO_LAST) begin
          w_state_nxt   = ST_RST_MMCM;
          w_cnt_nxt     = '0;
          w_retries_nxt = (r_retries == 8'hFF) ? r_retries : r_retries + 8'd1;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end

      ST_STABLE: begin
        // A lock dropout while qualifying the lock is not a timeout, so RETRIES is left alone.
        if (!r_lk_s) begin
          w_state_nxt = ST_WAIT_LOCK;
          w_cnt_nxt   = '0;
        end else if (r_cnt == C_STB_LAST) begin
          w_state_nxt = ST_RELEASE;
          w_cnt_nxt   = '0;
          w_idx_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end

      ST_RELEASE: begin
        // Lock loss is tested first so that it overrides a coincident release step.
        if (!r_lk_s) begin
          w_state_nxt     = ST_RST_MMCM;
          w_cnt_nxt       = '0;
          w_rst_out_nxt   = '1;
          w_ready_nxt     = 1'b0;
          w_lock_loss_nxt = 1'b1;
          w_loss_cnt_nxt  = (r_loss_cnt == 8'hFF) ? r_loss_cnt : r_loss_cnt + 8'd1;
        end else if (r_cnt == C_STG_LAST) begin
          w_rst_out_nxt[r_idx] = 1'b0;
          w_idx_nxt            = r_idx + IW'(1);
          w_cnt_nxt            = '0;
          if (r_idx == C_IDX_LAST) begin
            w_state_nxt = ST_RUN;
            w_ready_nxt = 1'b1;
          end
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end

      ST_RUN: begin
        if (!r_lk_s) begin
          w_state_nxt     = ST_RST_MMCM;
          w_cnt_nxt       = '0;
          w_rst_out_nxt   = '1;
          w_ready_nxt     = 1'b0;
          w_lock_loss_nxt = 1'b1;
          w_loss_cnt_nxt  = (r_loss_cnt == 8'hFF) ? r_loss_cnt : r_loss_cnt + 8'd1;
        end
      end

      default: begin
        w_state_nxt = ST_RST_MMCM;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // State register, output registers and lock synchronizer.
  always_ff @(posedge i_clk) begin
    // NOTE: reset is synchronous, so i_rst is tested inside the clocked block
    // and is not in the sensitivity list.
    if (i_rst) begin
      r_state     <= ST_RST_MMCM;
      r_cnt       <= '0;
      r_idx       <= '0;
      r_rst_out   <= '1;
      r_ready     <= 1'b0;
      r_retries   <= 8'd0;
      r_loss_cnt  <= 8'd0;
      r_lock_loss <= 1'b0;
      r_mmcm_rst  <= 1'b1;
      r_lk_meta   <= 1'b0;
      r_lk_s      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments. Every flop samples the value from before
      // the clock edge, and the synchronizer chain depends on this.
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_idx       <= w_idx_nxt;
      r_rst_out   <= w_rst_out_nxt;
      r_ready     <= w_ready_nxt;
      r_retries   <= w_retries_nxt;
      r_loss_cnt  <= w_loss_cnt_nxt;
      r_lock_loss <= w_lock_loss_nxt;
      // Registered from the next state, so MMCM_RST matches STATE==RST_MMCM on every cycle.
      r_mmcm_rst  <= (w_state_nxt == ST_RST_MMCM);
      r_lk_meta   <= io_seq.locked;
      r_lk_s      <= r_lk_meta;
    end
  end

  assign io_seq.mmcm_rst  = r_mmcm_rst;
  assign io_seq.rst_out   = r_rst_out;
  assign io_seq.ready     = r_ready;
  assign io_seq.state     = r_state;
  assign io_seq.retries   = r_retries;
  assign io_seq.loss_cnt  = r_loss_cnt;
  assign io_seq.lock_loss = r_lock_loss;

endmodule

// File: tb/tb_clk_rst_seq.sv
// -----------------------------------------------------------------------------
// tb_clk_rst_seq
//   Self-checking bench for clk_rst_seq with small parameters
//   (NCH=3, RST_CYCLES=8, LOCK_TIMEOUT=32, LOCK_STABLE=4, STAGGER=2).
//   Each step drives RST/LOCKED for N cycles and pushes the outputs expected
//   after the last of those edges. The expectation is popped and compared
//   1 time unit after that edge.
// -----------------------------------------------------------------------------
module tb_clk_rst_seq;

  localparam int NCH = 3;

  typedef struct {
    logic [2:0] state;
    logic       mmcm_rst;
    logic [2:0] rst_out;
    logic       ready;
    logic       lock_loss;
    logic [7:0] retries;
    logic [7:0] loss_cnt;
  } exp_t;

  typedef struct {
    int unsigned ncyc;
    logic        rst;
    logic        locked;
    exp_t        e;
  } vec_t;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;
  exp_t sb_q[$];
  vec_t vecs[$];

  clk_rst_seq_if #(.NCH(NCH)) seq_if ();

  clk_rst_seq #(
    .NCH          (NCH),
    .RST_CYCLES   (8),
    .LOCK_TIMEOUT (32),
    .LOCK_STABLE  (4),
    .STAGGER      (2)
  ) dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .io_seq (seq_if)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, summary not reached");
    $fatal(1, "watchdog");
  end

  // Builds an expectation record. MMCM_RST is high exactly while the state is RST_MMCM.
  function automatic exp_t mk(input int st, input int ro, input int rdy,
                              input int ll, input int ret, input int loss);
    exp_t e;
    e.state     = 3'(st);
    e.mmcm_rst  = (st == 0);
    e.rst_out   = 3'(ro);
    e.ready     = 1'(rdy);
    e.lock_loss = 1'(ll);
    e.retries   = 8'(ret);
    e.loss_cnt  = 8'(loss);
    return e;
  endfunction

  function automatic void add_vec(input int unsigned n, input logic r, input logic lk, input exp_t e);
    vec_t v;
    v.ncyc   = n;
    v.rst    = r;
    v.locked = lk;
    v.e      = e;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input exp_t e);
    logic [23:0] got;
    logic [23:0] want;
    got  = {seq_if.state, seq_if.mmcm_rst, seq_if.rst_out, seq_if.ready,
            seq_if.lock_loss, seq_if.retries, seq_if.loss_cnt};
    want = {e.state, e.mmcm_rst, e.rst_out, e.ready, e.lock_loss, e.retries, e.loss_cnt};
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got st=%0d mm=%b ro=%b rdy=%b ll=%b ret=%0d loss=%0d, expected st=%0d mm=%b ro=%b rdy=%b ll=%b ret=%0d loss=%0d",
               name, seq_if.state, seq_if.mmcm_rst, seq_if.rst_out, seq_if.ready,
               seq_if.lock_loss, seq_if.retries, seq_if.loss_cnt,
               e.state, e.mmcm_rst, e.rst_out, e.ready, e.lock_loss, e.retries, e.loss_cnt);
    end
  endtask

  // Drive inputs for n cycles. Compare against the expectation after the last edge.
  task automatic run(input string name, input int unsigned n, input logic r,
                     input logic lk, input exp_t e);
    exp_t got_e;
    rst           = r;
    seq_if.locked = lk;
    sb_q.push_back(e);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
    got_e = sb_q.pop_front();
    check(name, got_e);
  endtask

  initial begin
    n_checks      = 0;
    n_errors      = 0;
    rst           = 1'b1;
    seq_if.locked = 1'b0;

    // Normal bring-up (edges counted from RST falling) with LOCKED=1 throughout.
    add_vec(3,  1, 1, mk(0, 7, 0, 0, 0, 0));   // reset values
    add_vec(7,  0, 1, mk(0, 7, 0, 0, 0, 0));   // edge 7: still pulsing MMCM reset
    add_vec(1,  0, 1, mk(1, 7, 0, 0, 0, 0));   // edge 8: WAIT_LOCK
    add_vec(1,  0, 1, mk(2, 7, 0, 0, 0, 0));   // edge 9: STABLE
    add_vec(3,  0, 1, mk(2, 7, 0, 0, 0, 0));   // edge 12
    add_vec(1,  0, 1, mk(3, 7, 0, 0, 0, 0));   // edge 13: RELEASE
    add_vec(1,  0, 1, mk(3, 7, 0, 0, 0, 0));   // edge 14
    add_vec(1,  0, 1, mk(3, 6, 0, 0, 0, 0));   // edge 15: bit0 released
    add_vec(2,  0, 1, mk(3, 4, 0, 0, 0, 0));   // edge 17: bit1 released
    add_vec(1,  0, 1, mk(3, 4, 0, 0, 0, 0));   // edge 18
    add_vec(1,  0, 1, mk(4, 0, 1, 0, 0, 0));   // edge 19: RUN, READY
    add_vec(5,  0, 1, mk(4, 0, 1, 0, 0, 0));   // edge 24: holds
    // Lock loss in RUN: LOCKED falls before edge 25 and lk_s is low for edge 27.
    add_vec(2,  0, 0, mk(4, 0, 1, 0, 0, 0));   // edge 26
    add_vec(1,  0, 0, mk(0, 7, 0, 1, 0, 1));   // edge 27: forced back, pulse
    add_vec(1,  0, 0, mk(0, 7, 0, 0, 0, 1));   // edge 28: pulse is one cycle
    add_vec(6,  0, 1, mk(0, 7, 0, 0, 0, 1));   // edge 34
    add_vec(1,  0, 1, mk(1, 7, 0, 0, 0, 1));   // edge 35
    add_vec(1,  0, 1, mk(2, 7, 0, 0, 0, 1));   // edge 36
    add_vec(4,  0, 1, mk(3, 7, 0, 0, 0, 1));   // edge 40
    add_vec(6,  0, 1, mk(4, 0, 1, 0, 0, 1));   // edge 46: RUN again
    // lk_s falls on the edge of the bit1 release step. Bit1 must stay in reset.
    add_vec(2,  1, 1, mk(0, 7, 0, 0, 0, 0));
    add_vec(14, 0, 1, mk(3, 7, 0, 0, 0, 0));   // edge 14
    add_vec(1,  0, 0, mk(3, 6, 0, 0, 0, 0));   // edge 15
    add_vec(1,  0, 0, mk(3, 6, 0, 0, 0, 0));   // edge 16
    add_vec(1,  0, 0, mk(0, 7, 0, 1, 0, 1));   // edge 17: 110 -> 111

    for (int i = 0; i < vecs.size(); i++)
      run($sformatf("vec%0d", i), vecs[i].ncyc, vecs[i].rst, vecs[i].locked, vecs[i].e);

    // LOCKED held low: a retry every 40 cycles, saturating at 255.
    run("to_rst",      2, 1, 0, mk(0, 7, 0, 0, 0, 0));
    run("to_wait_end", 39, 0, 0, mk(1, 7, 0, 0, 0, 0));
    run("to_retry1",   1, 0, 0, mk(0, 7, 0, 0, 1, 0));
    run("to_repulse",  7, 0, 0, mk(0, 7, 0, 0, 1, 0));
    run("to_wait2",    1, 0, 0, mk(1, 7, 0, 0, 1, 0));
    run("to_retry2",   32, 0, 0, mk(0, 7, 0, 0, 2, 0));
    for (int n = 3; n <= 257; n++)
      run($sformatf("to_retry%0d", n), 40, 0, 0,
          mk(0, 7, 0, 0, (n > 255) ? 255 : n, 0));

    // Lock, lose the lock in RUN, then relock. Assert RST mid-release with RST_OUT=110.
    run("sat_run",     19, 0, 1, mk(4, 0, 1, 0, 255, 0));
    run("sat_loss",    3,  0, 0, mk(0, 7, 0, 1, 255, 1));
    run("mid_rel",     15, 0, 1, mk(3, 6, 0, 0, 255, 1));
    run("rst_mid_rel", 1,  1, 1, mk(0, 7, 0, 0, 0, 0));

    // Two-cycle LOCKED dropout while in STABLE.
    run("gl_rst",      1, 1, 1, mk(0, 7, 0, 0, 0, 0));
    run("gl_stable",   9, 0, 1, mk(2, 7, 0, 0, 0, 0));
    run("gl_drop",     2, 0, 0, mk(2, 7, 0, 0, 0, 0));
    run("gl_wait",     1, 0, 1, mk(1, 7, 0, 0, 0, 0));
    run("gl_wait2",    1, 0, 1, mk(1, 7, 0, 0, 0, 0));
    run("gl_relock",   1, 0, 1, mk(2, 7, 0, 0, 0, 0));
    run("gl_count",    3, 0, 1, mk(2, 7, 0, 0, 0, 0));
    run("gl_release",  1, 0, 1, mk(3, 7, 0, 0, 0, 0));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
